// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: per-stage stall, bubble and flush vectors from stall/redirect requests.
// Zero-latency combinational outputs; redirects blocked by an older stall are held and issued on release.
module pipe_hazard_ctrl #(
  parameter int NUM_STAGES = 6,
  parameter int TIMEOUT    = 1024,
  parameter int CNT_W      = 32,
  localparam int SW        = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_STAGES-1:0] stall_req,
  input  logic [NUM_STAGES-1:0] flush_req,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] bubble,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  redirect_valid,
  output logic [SW-1:0]         redirect_src,
  output logic                  flush_pending,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic                  stall_timeout
);

  localparam int RW = $clog2(TIMEOUT + 1);

  logic [NUM_STAGES-1:0] pend_q, pend_d;
  logic [NUM_STAGES-1:0] eff;
  logic                  has_stall, has_flush, issue, any_stall;
  logic [SW-1:0]         hs_idx, f_idx;
  logic [RW-1:0]         run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;
  logic                  timeout_q, timeout_d;

  // Stage 0 (PC) cannot redirect itself, so its flush bit is masked out.
  assign eff = (flush_req | pend_q) & ~NUM_STAGES'(1);

  always_comb begin
    has_stall = 1'b0;
    hs_idx    = '0;
    has_flush = 1'b0;
    f_idx     = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (stall_req[k]) begin
        has_stall = 1'b1;
        hs_idx    = SW'(k);
      end
      if (eff[k]) begin
        has_flush = 1'b1;
        f_idx     = SW'(k);
      end
    end
  end

  // A redirect is only taken when every stalling stage is younger than it.
  assign issue = has_flush && (!has_stall || (hs_idx < f_idx));

  always_comb begin
    stall          = '0;
    bubble         = '0;
    flush          = '0;
    redirect_valid = 1'b0;
    redirect_src   = '0;
    flush_pending  = 1'b0;
    if (!rst) begin
      flush_pending = |pend_q;
      if (issue) begin
        redirect_valid = 1'b1;
        redirect_src   = f_idx;
        for (int j = 1; j < NUM_STAGES; j++) begin
          flush[j] = (SW'(j) < f_idx);
        end
      end else if (has_stall) begin
        for (int j = 0; j < NUM_STAGES; j++) begin
          stall[j] = (SW'(j) <= hs_idx);
          if (j > 0) begin
            bubble[j] = (SW'(j - 1) == hs_idx);
          end
        end
      end
    end
  end

  assign any_stall = |stall;

  always_comb begin
    pend_d = pend_q;
    if (issue) begin
      pend_d = '0;
    end else if (has_flush) begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        pend_d[k] = (SW'(k) == f_idx);
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    run_cnt_d   = run_cnt_q;
    timeout_d   = timeout_q;
    if (any_stall) begin
      if (stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if (run_cnt_q != RW'(TIMEOUT)) begin
        run_cnt_d = run_cnt_q + 1'b1;
      end
      if (run_cnt_q == RW'(TIMEOUT - 1)) begin
        timeout_d = 1'b1;
      end
    end else begin
      run_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q      <= '0;
      run_cnt_q   <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      run_cnt_q   <= run_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign stall_cnt     = stall_cnt_q;
  assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic, scored against a queue-fed reference model.
module tb_pipe_hazard_ctrl;

  localparam int N   = 6;
  localparam int TO  = 4;
  localparam int CW  = 8;
  localparam int SWD = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   stall_req = '0;
  logic [N-1:0]   flush_req = '0;
  logic [N-1:0]   stall, bubble, flush;
  logic           redirect_valid;
  logic [SWD-1:0] redirect_src;
  logic           flush_pending;
  logic [CW-1:0]  stall_cnt;
  logic           stall_timeout;

  pipe_hazard_ctrl #(.NUM_STAGES(N), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
    .stall(stall), .bubble(bubble), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_src(redirect_src),
    .flush_pending(flush_pending), .stall_cnt(stall_cnt), .stall_timeout(stall_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st, bb, fl, rv, src, fp, cnt, to;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference state: pending redirect as a stage number (-1 = none), counters as plain integers.
  int m_pend = -1;
  int m_run  = 0;
  int m_cnt  = 0;
  bit m_to   = 1'b0;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
    end
  endtask

  task automatic cyc(input bit r, input logic [N-1:0] sr, input logic [N-1:0] fr, input bit push);
    exp_t e;
    int hs, f;
    bit iss;
    @(posedge clk);
    #1;
    rst = r; stall_req = sr; flush_req = fr;
    hs = -1;
    for (int k = 0; k < N; k++) if (sr[k]) hs = k;
    f = m_pend;
    for (int k = 1; k < N; k++) if (fr[k] && k > f) f = k;
    iss = (f > 0) && (hs < f);
    e.cnt = m_cnt; e.to = int'(m_to);
    if (r) begin
      e.st = 0; e.bb = 0; e.fl = 0; e.rv = 0; e.src = 0; e.fp = 0;
    end else begin
      e.fp  = (m_pend >= 0) ? 1 : 0;
      e.rv  = iss ? 1 : 0;
      e.src = iss ? f : 0;
      e.fl  = iss ? (((1 << f) - 1) & ~1) : 0;
      e.st  = (!iss && hs >= 0) ? ((1 << (hs + 1)) - 1) : 0;
      e.bb  = (!iss && hs >= 0 && hs + 1 < N) ? (1 << (hs + 1)) : 0;
    end
    if (push) exp_q.push_back(e);
    if (r) begin
      m_pend = -1; m_run = 0; m_cnt = 0; m_to = 1'b0;
    end else begin
      if (iss) m_pend = -1;
      else if (f > 0) m_pend = f;
      if (e.st != 0) begin
        if (m_cnt < (1 << CW) - 1) m_cnt++;
        if (m_run == TO - 1) m_to = 1'b1;
        if (m_run < TO) m_run++;
      end else begin
        m_run = 0;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall",          int'(stall),          e.st);
        chk("bubble",         int'(bubble),         e.bb);
        chk("flush",          int'(flush),          e.fl);
        chk("redirect_valid", int'(redirect_valid), e.rv);
        chk("redirect_src",   int'(redirect_src),   e.src);
        chk("flush_pending",  int'(flush_pending),  e.fp);
        chk("stall_cnt",      int'(stall_cnt),      e.cnt);
        chk("stall_timeout",  int'(stall_timeout),  e.to);
      end
    end
  end

  initial begin : driver
    logic [N-1:0] sr, fr;
    cyc(1'b1, '0, '0, 1'b0);
    cyc(1'b1, '0, '0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1);
    // single stall at stage 4
    repeat (3) cyc(1'b0, 6'b010000, '0, 1'b1);
    // immediate redirect from stage 3
    cyc(1'b0, '0, 6'b001000, 1'b1);
    cyc(1'b0, '0, '0, 1'b1);
    // redirect deferred behind an older stall
    cyc(1'b0, 6'b010000, 6'b001000, 1'b1);
    cyc(1'b0, 6'b010000, '0, 1'b1);
    cyc(1'b0, 6'b010000, '0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1);
    // younger stall loses to an older redirect
    cyc(1'b0, 6'b000100, 6'b001000, 1'b1);
    // pending redirect replaced by a higher one
    cyc(1'b0, 6'b010000, 6'b001000, 1'b1);
    cyc(1'b0, 6'b100000, 6'b010000, 1'b1);
    cyc(1'b0, '0, '0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1);
    // watchdog
    repeat (4) cyc(1'b0, 6'b000100, '0, 1'b1);
    repeat (3) cyc(1'b0, '0, '0, 1'b1);
    // reset drops a pending redirect
    cyc(1'b0, 6'b100000, 6'b010000, 1'b1);
    cyc(1'b1, '0, '0, 1'b1);
    repeat (2) cyc(1'b0, '0, '0, 1'b1);
    // stall counter saturation
    repeat (270) cyc(1'b0, 6'b000001, '0, 1'b1);
    cyc(1'b0, '0, '0, 1'b1);
    // random traffic with occasional reset
    for (int i = 0; i < 400; i++) begin
      sr = '0; fr = '0;
      for (int k = 0; k < N; k++) begin
        sr[k] = ($urandom_range(0, 5) == 0);
        fr[k] = ($urandom_range(0, 6) == 0);
      end
      cyc(($urandom_range(0, 63) == 0), sr, fr, 1'b1);
    end
    repeat (2) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
